// File: rtl/trisc_sequencer_pkg.sv
// trisc_sequencer_pkg: shared definitions for the TRISC2 sequencer.
//   - opcode constants (IR[7:4])
//   - ALU operation codes driven on alu_op
//   - FSM state encoding, opcode classes and the strobe vector type
package trisc_sequencer_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   // S_LOAD and S_CLR carry the loader session: RAM granted, then PC clear.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEM    = 4'd4,
      S_WB     = 4'd5,
      S_HALT   = 4'd6,
      S_LOAD   = 4'd7,
      S_CLR    = 4'd8
   } state_e;

   typedef enum logic [3:0] {
      K_NOP, K_LDA, K_STA, K_ADD, K_SUB, K_JMP, K_JZ, K_JC, K_HLT
   } op_kind_e;

   typedef struct packed {
      logic       ld_grant;
      logic       pc_inc;
      logic       pc_load;
      logic       pc_clr;
      logic       addr_sel;
      logic       ram_en;
      logic       ram_wr;
      logic       ir_load;
      logic [1:0] alu_op;
      logic       alu_latch;
      logic       acc_load;
      logic       acc_src;
      logic       halted;
   } strobes_t;

   // Opcodes 8..E are reserved and behave as NOP.
   function automatic op_kind_e op_kind(input logic [3:0] op);
      op_kind_e k;
      case (op)
         OP_LDA:  k = K_LDA;
         OP_STA:  k = K_STA;
         OP_ADD:  k = K_ADD;
         OP_SUB:  k = K_SUB;
         OP_JMP:  k = K_JMP;
         OP_JZ:   k = K_JZ;
         OP_JC:   k = K_JC;
         OP_HLT:  k = K_HLT;
         default: k = K_NOP;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/trisc_sequencer_decode.sv
// trisc_sequencer_decode: combinational map from (state, opcode, flags) to
// the datapath strobe vector.
//   i_state     current sequencer state
//   i_ir_op     opcode held in IR
//   i_acc_zero  accumulator-zero flag (JZ)
//   i_alu_cout  ALU carry flag (JC)
//   o_kind      opcode class, shared with the state register in the top
//   o_strobes   all datapath strobes plus ld_grant / halted
module trisc_sequencer_decode
   import trisc_sequencer_pkg::*;
#(
   parameter int OPW = 4
) (
   input  state_e         i_state,
   input  logic [OPW-1:0] i_ir_op,
   input  logic           i_acc_zero,
   input  logic           i_alu_cout,
   output op_kind_e       o_kind,
   output strobes_t       o_strobes
);

   op_kind_e w_kind;
   strobes_t w_s;

   assign w_kind = op_kind(i_ir_op);

   always_comb begin
      w_s = '0;
      case (i_state)
         S_FETCH: w_s.ram_en = 1'b1;
         S_DECODE: begin
            w_s.ir_load = 1'b1;
            w_s.pc_inc  = 1'b1;
         end
         S_EXEC: begin
            case (w_kind)
               K_LDA, K_ADD, K_SUB: begin
                  w_s.addr_sel = 1'b1;
                  w_s.ram_en   = 1'b1;
               end
               K_STA: begin
                  w_s.addr_sel = 1'b1;
                  w_s.ram_en   = 1'b1;
                  w_s.ram_wr   = 1'b1;
               end
               K_JMP:   w_s.pc_load = 1'b1;
               K_JZ:    w_s.pc_load = i_acc_zero;
               K_JC:    w_s.pc_load = i_alu_cout;
               default: ;
            endcase
         end
         S_MEM: begin
            case (w_kind)
               K_LDA: w_s.acc_load = 1'b1;
               K_ADD: begin
                  w_s.alu_op    = ALU_ADD;
                  w_s.alu_latch = 1'b1;
               end
               K_SUB: begin
                  w_s.alu_op    = ALU_SUB;
                  w_s.alu_latch = 1'b1;
               end
               default: ;
            endcase
         end
         S_WB: begin
            w_s.acc_load = 1'b1;
            w_s.acc_src  = 1'b1;
         end
         S_HALT:  w_s.halted   = 1'b1;
         S_LOAD:  w_s.ld_grant = 1'b1;
         S_CLR:   w_s.pc_clr   = 1'b1;
         default: ;
      endcase
   end

   assign o_kind    = w_kind;
   assign o_strobes = w_s;

endmodule

// File: rtl/trisc_sequencer.sv
// trisc_sequencer: fetch/decode/execute sequencer and RAM-port arbiter for
// the TRISC2 accumulator CPU.
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_run, i_step           free-run level / single-instruction pulse
//   i_ir_op                 opcode from IR
//   i_acc_zero, i_alu_cout  jump condition flags
//   i_ld_req                manual loader RAM request
//   o_ld_grant              loader owns RAM
//   o_pc_*                  PC increment / load / clear
//   o_addr_sel, o_ram_en, o_ram_wr, o_ir_load
//   o_alu_op, o_alu_latch, o_acc_load, o_acc_src, o_halted
//
// state  | meaning
// IDLE   | waiting for run/step or a loader request
// FETCH  | RAM read at PC
// DECODE | IR captures RAM data, PC increments
// EXEC   | operand access, store, jump or halt
// MEM    | operand valid: LDA loads ACC, ADD/SUB latch ALU
// WB     | ACC loads from ALU buffer
// HALT   | stopped until reset or loader session
// LOAD   | loader owns the RAM port
// CLR    | loader released: one-cycle PC clear, then IDLE
module trisc_sequencer
   import trisc_sequencer_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic           i_clock,
   input  logic           i_reset,
   input  logic           i_run,
   input  logic           i_step,
   input  logic [OPW-1:0] i_ir_op,
   input  logic           i_acc_zero,
   input  logic           i_alu_cout,
   input  logic           i_ld_req,
   output logic           o_ld_grant,
   output logic           o_pc_inc,
   output logic           o_pc_load,
   output logic           o_pc_clr,
   output logic           o_addr_sel,
   output logic           o_ram_en,
   output logic           o_ram_wr,
   output logic           o_ir_load,
   output logic [1:0]     o_alu_op,
   output logic           o_alu_latch,
   output logic           o_acc_load,
   output logic           o_acc_src,
   output logic           o_halted
);

   state_e   r_state;
   state_e   w_end_state;
   op_kind_e w_kind;
   strobes_t w_strobes;

   // Strobes decode the registered state directly: EXEC/MEM/WB need the
   // opcode that IR only captures at the end of DECODE, so they cannot be
   // precomputed a cycle early.
   trisc_sequencer_decode #(.OPW(OPW)) u_decode (
      .i_state    (r_state),
      .i_ir_op    (i_ir_op),
      .i_acc_zero (i_acc_zero),
      .i_alu_cout (i_alu_cout),
      .o_kind     (w_kind),
      .o_strobes  (w_strobes)
   );

   // A pending loader request wins at the instruction boundary so a
   // free-running CPU cannot starve the loader.
   always_comb begin
      w_end_state = S_IDLE;
      if (i_ld_req)
         w_end_state = S_LOAD;
      else if (i_run)
         w_end_state = S_FETCH;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_ld_req)
                  r_state <= S_LOAD;
               else if (i_run || i_step)
                  r_state <= S_FETCH;
            end
            S_FETCH:  r_state <= S_DECODE;
            S_DECODE: r_state <= S_EXEC;
            S_EXEC: begin
               case (w_kind)
                  K_LDA, K_ADD, K_SUB: r_state <= S_MEM;
                  K_HLT:               r_state <= S_HALT;
                  default:             r_state <= w_end_state;
               endcase
            end
            S_MEM: begin
               if (w_kind == K_LDA)
                  r_state <= w_end_state;
               else
                  r_state <= S_WB;
            end
            S_WB: r_state <= w_end_state;
            S_HALT: begin
               if (i_ld_req)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               if (!i_ld_req)
                  r_state <= S_CLR;
            end
            S_CLR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ld_grant  = w_strobes.ld_grant;
   assign o_pc_inc    = w_strobes.pc_inc;
   assign o_pc_load   = w_strobes.pc_load;
   assign o_pc_clr    = w_strobes.pc_clr;
   assign o_addr_sel  = w_strobes.addr_sel;
   assign o_ram_en    = w_strobes.ram_en;
   assign o_ram_wr    = w_strobes.ram_wr;
   assign o_ir_load   = w_strobes.ir_load;
   assign o_alu_op    = w_strobes.alu_op;
   assign o_alu_latch = w_strobes.alu_latch;
   assign o_acc_load  = w_strobes.acc_load;
   assign o_acc_src   = w_strobes.acc_src;
   assign o_halted    = w_strobes.halted;

endmodule

// File: tb/tb_trisc_sequencer.sv
// tb_trisc_sequencer: sequencer driving a small TRISC2 datapath model
// (RAM, PC, IR, ACC, ALU). An instruction-set model predicts the strobe
// word of every cycle; a negedge monitor pops and compares.
module tb_trisc_sequencer;

   localparam logic [13:0] M_GRANT = 14'h2000;
   localparam logic [13:0] M_INC   = 14'h1000;
   localparam logic [13:0] M_LOAD  = 14'h0800;
   localparam logic [13:0] M_CLR   = 14'h0400;
   localparam logic [13:0] M_ASEL  = 14'h0200;
   localparam logic [13:0] M_REN   = 14'h0100;
   localparam logic [13:0] M_RWR   = 14'h0080;
   localparam logic [13:0] M_IRL   = 14'h0040;
   localparam logic [13:0] M_OP1   = 14'h0020;
   localparam logic [13:0] M_OP0   = 14'h0010;
   localparam logic [13:0] M_LATCH = 14'h0008;
   localparam logic [13:0] M_ACCL  = 14'h0004;
   localparam logic [13:0] M_SRC   = 14'h0002;
   localparam logic [13:0] M_HALT  = 14'h0001;
   localparam logic [13:0] M_CPU   = 14'h1FFE;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       i_reset, i_run, i_step, i_ld_req;
   logic [3:0] i_ir_op;
   logic       i_acc_zero, i_alu_cout;
   logic       o_ld_grant, o_pc_inc, o_pc_load, o_pc_clr, o_addr_sel;
   logic       o_ram_en, o_ram_wr, o_ir_load, o_alu_latch, o_acc_load;
   logic       o_acc_src, o_halted;
   logic [1:0] o_alu_op;

   trisc_sequencer #(.OPW(4)) dut (
      .i_clock(clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
      .i_ir_op(i_ir_op), .i_acc_zero(i_acc_zero), .i_alu_cout(i_alu_cout),
      .i_ld_req(i_ld_req), .o_ld_grant(o_ld_grant), .o_pc_inc(o_pc_inc),
      .o_pc_load(o_pc_load), .o_pc_clr(o_pc_clr), .o_addr_sel(o_addr_sel),
      .o_ram_en(o_ram_en), .o_ram_wr(o_ram_wr), .o_ir_load(o_ir_load),
      .o_alu_op(o_alu_op), .o_alu_latch(o_alu_latch),
      .o_acc_load(o_acc_load), .o_acc_src(o_acc_src), .o_halted(o_halted)
   );

   wire [13:0] obs = {o_ld_grant, o_pc_inc, o_pc_load, o_pc_clr, o_addr_sel,
                      o_ram_en, o_ram_wr, o_ir_load, o_alu_op, o_alu_latch,
                      o_acc_load, o_acc_src, o_halted};

   // ---------------- datapath model driven by the DUT strobes ----------
   logic [7:0] dp_mem [16];
   logic [7:0] dp_img [16];
   logic       dp_load;
   logic [3:0] dp_pc;
   logic [7:0] dp_ir, dp_acc, dp_q, dp_buf;
   logic       dp_c;
   wire  [3:0] dp_addr = o_addr_sel ? dp_ir[3:0] : dp_pc;
   wire  [8:0] dp_sum  = (o_alu_op == 2'b10) ?
                         ({1'b0, dp_acc} + {1'b0, ~dp_q} + 9'd1) :
                         ({1'b0, dp_acc} + {1'b0, dp_q});

   assign i_ir_op    = dp_ir[7:4];
   assign i_acc_zero = (dp_acc == 8'h00);
   assign i_alu_cout = dp_c;

   always @(posedge clk) begin
      if (dp_load)
         dp_mem <= dp_img;
      else if (o_ram_en && o_ram_wr)
         dp_mem[dp_addr] <= dp_acc;
      if (i_reset) begin
         dp_pc <= 4'h0; dp_ir <= 8'h00; dp_acc <= 8'h00;
         dp_q <= 8'h00; dp_buf <= 8'h00; dp_c <= 1'b0;
      end else begin
         if (o_ram_en && !o_ram_wr) dp_q <= dp_mem[dp_addr];
         if (o_ir_load) dp_ir <= dp_q;
         if (o_pc_clr)       dp_pc <= 4'h0;
         else if (o_pc_load) dp_pc <= dp_ir[3:0];
         else if (o_pc_inc)  dp_pc <= dp_pc + 4'h1;
         if (o_alu_latch) begin
            dp_buf <= dp_sum[7:0];
            dp_c   <= dp_sum[8];
         end
         if (o_acc_load) dp_acc <= o_acc_src ? dp_buf : dp_q;
      end
   end

   // ---------------- scoreboard ----------------------------------------
   logic [13:0] exp_q [$];
   string       c_nm  [$];
   logic [7:0]  c_act [$];
   logic [7:0]  c_exp [$];
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
      c_nm.push_back(nm);
      c_act.push_back(a);
      c_exp.push_back(e);
   endtask

   initial begin
      logic [13:0] e;
      logic [7:0]  a, x;
      string       nm;
      forever begin
         @(negedge clk);
         if (o_ld_grant) begin
            total++;
            if ((obs & M_CPU) != 14'h0) begin
               bad++;
               $display("FAIL grant_excl t=%0t strobes=%h must be %h", $time, obs & M_CPU, 14'h0);
            end
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
               bad++;
               $display("FAIL strobes t=%0t got=%h want=%h", $time, obs, e);
            end
         end
         while (c_nm.size() > 0) begin
            nm = c_nm.pop_front();
            a  = c_act.pop_front();
            x  = c_exp.pop_front();
            total++;
            if (a !== x) begin
               bad++;
               $display("FAIL %s got=%h want=%h", nm, a, x);
            end
         end
      end
   end

   // Expect word for the current cycle, then advance one cycle.
   task automatic cyc(input logic [13:0] e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // ---------------- instruction-set reference model -------------------
   logic [13:0] iss_tr [$];
   logic        iss_ok;
   logic [3:0]  iss_pc;
   logic [7:0]  iss_acc;
   logic [7:0]  iss_mem [16];

   task automatic iss_run(input logic [7:0] img [16]);
      logic [7:0] m [16];
      logic [3:0] pc, a;
      logic [7:0] acc, ir;
      logic [8:0] s;
      logic       c;
      m = img; pc = 4'h0; acc = 8'h00; c = 1'b0;
      iss_ok = 1'b0;
      iss_tr.delete();
      iss_tr.push_back(14'h0);
      for (int n = 0; n < 24 && !iss_ok; n++) begin
         ir = m[pc]; a = ir[3:0]; pc = pc + 4'h1;
         iss_tr.push_back(M_REN);
         iss_tr.push_back(M_IRL | M_INC);
         case (ir[7:4])
            4'h1: begin
               iss_tr.push_back(M_ASEL | M_REN); iss_tr.push_back(M_ACCL);
               acc = m[a];
            end
            4'h2: begin
               iss_tr.push_back(M_ASEL | M_REN | M_RWR);
               m[a] = acc;
            end
            4'h3, 4'h4: begin
               iss_tr.push_back(M_ASEL | M_REN);
               iss_tr.push_back(((ir[7:4] == 4'h3) ? M_OP0 : M_OP1) | M_LATCH);
               iss_tr.push_back(M_ACCL | M_SRC);
               if (ir[7:4] == 4'h3) s = {1'b0, acc} + {1'b0, m[a]};
               else                 s = {1'b0, acc} + {1'b0, ~m[a]} + 9'd1;
               acc = s[7:0]; c = s[8];
            end
            4'h5: begin iss_tr.push_back(M_LOAD); pc = a; end
            4'h6: begin
               iss_tr.push_back((acc == 8'h0) ? M_LOAD : 14'h0);
               if (acc == 8'h0) pc = a;
            end
            4'h7: begin
               iss_tr.push_back(c ? M_LOAD : 14'h0);
               if (c) pc = a;
            end
            4'hF: begin
               iss_tr.push_back(14'h0);
               iss_tr.push_back(M_HALT);
               iss_ok = 1'b1;
            end
            default: iss_tr.push_back(14'h0);
         endcase
      end
      iss_pc = pc; iss_acc = acc; iss_mem = m;
   endtask

   // ---------------- stimulus ------------------------------------------
   logic [7:0] img [16];
   logic [3:0] ops [10];

   task automatic load_reset(input logic [7:0] im [16]);
      dp_img = im; dp_load = 1'b1; i_reset = 1'b1;
      i_run = 1'b0; i_step = 1'b0; i_ld_req = 1'b0;
      @(posedge clk);
      #1;
      dp_load = 1'b0; i_reset = 1'b0;
   endtask

   task automatic run_program(input logic [7:0] im [16], input logic use_step);
      int nb;
      load_reset(im);
      iss_run(im);
      foreach (iss_tr[i]) exp_q.push_back(iss_tr[i]);
      i_run = 1'b1; i_step = use_step;
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 8'(exp_q.size()), 8'h00);
         exp_q.delete();
      end
      chk("prog_pc", {4'h0, dp_pc}, {4'h0, iss_pc});
      chk("prog_acc", dp_acc, iss_acc);
      nb = 0;
      foreach (iss_mem[i]) if (dp_mem[i] !== iss_mem[i]) nb++;
      chk("prog_mem_diffs", 8'(nb), 8'h00);
      for (int k = 0; k < 4; k++) begin
         i_run = 1'($urandom_range(0, 1));
         cyc(M_HALT);
      end
      i_run = 1'b0; i_step = 1'b0;
   endtask

   task automatic clear_img();
      foreach (img[i]) img[i] = 8'h00;
   endtask

   initial begin
      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hF};
      i_reset = 1'b1; i_run = 1'b0; i_step = 1'b0; i_ld_req = 1'b0;
      dp_load = 1'b0;
      foreach (dp_img[i]) dp_img[i] = 8'h00;
      @(posedge clk);
      #1;
      cyc(14'h0);
      cyc(14'h0);
      i_reset = 1'b0;
      cyc(14'h0);
      cyc(14'h0);

      // LDA 9, ADD A, JZ (not taken), SUB B, JZ (taken) to C, HLT
      clear_img();
      img[0] = 8'h19; img[1] = 8'h3A; img[2] = 8'h6C; img[3] = 8'h4B;
      img[4] = 8'h6C; img[5] = 8'hF0; img[9] = 8'h05; img[10] = 8'h03;
      img[11] = 8'h08; img[12] = 8'hF0;
      run_program(img, 1'b0);
      chk("dirA_acc", dp_acc, 8'h00);
      chk("dirA_pc", {4'h0, dp_pc}, 8'h0D);

      // loader session out of HALT
      i_ld_req = 1'b1;
      cyc(M_HALT);
      cyc(M_GRANT);
      i_ld_req = 1'b0;
      cyc(M_GRANT);
      cyc(M_CLR);
      cyc(14'h0);
      chk("ld_pc_clr", {4'h0, dp_pc}, 8'h00);

      // JC taken: 0xF0 + 0x20 carries out
      clear_img();
      img[0] = 8'h19; img[1] = 8'h3A; img[2] = 8'h7E; img[3] = 8'hF0;
      img[9] = 8'hF0; img[10] = 8'h20; img[14] = 8'hF0;
      run_program(img, 1'b1);
      chk("jc_pc", {4'h0, dp_pc}, 8'h0F);
      chk("jc_acc", dp_acc, 8'h10);

      // random programs that halt within the model's instruction budget
      for (int r = 0; r < 8; r++) begin
         iss_ok = 1'b0;
         for (int t = 0; t < 200 && !iss_ok; t++) begin
            foreach (img[i]) img[i] = {ops[$urandom_range(0, 9)], 4'($urandom)};
            iss_run(img);
         end
         if (!iss_ok) begin
            clear_img();
            img[0] = 8'hF0;
         end
         run_program(img, 1'($urandom_range(0, 1)));
      end

      // single step of LDA 9 with run low
      clear_img();
      img[0] = 8'h19; img[1] = 8'h2E; img[9] = 8'h77; img[14] = 8'h11;
      load_reset(img);
      i_step = 1'b1;
      cyc(14'h0);
      i_step = 1'b0;
      cyc(M_REN);
      cyc(M_IRL | M_INC);
      cyc(M_ASEL | M_REN);
      cyc(M_ACCL);
      cyc(14'h0);
      cyc(14'h0);
      chk("step_acc", dp_acc, 8'h77);
      chk("step_pc", {4'h0, dp_pc}, 8'h01);

      // step STA, reset during its EXEC cycle
      i_step = 1'b1;
      cyc(14'h0);
      i_step = 1'b0;
      cyc(M_REN);
      cyc(M_IRL | M_INC);
      i_reset = 1'b1;
      cyc(M_ASEL | M_REN | M_RWR);
      i_reset = 1'b0;
      cyc(14'h0);
      cyc(14'h0);

      // loader request raised during ADD is held off until after WB
      clear_img();
      img[0] = 8'h19; img[1] = 8'h3A; img[2] = 8'hF0;
      img[9] = 8'h05; img[10] = 8'h03;
      load_reset(img);
      i_run = 1'b1;
      cyc(14'h0);
      cyc(M_REN);
      cyc(M_IRL | M_INC);
      cyc(M_ASEL | M_REN);
      cyc(M_ACCL);
      cyc(M_REN);
      cyc(M_IRL | M_INC);
      i_ld_req = 1'b1; i_run = 1'b0;
      cyc(M_ASEL | M_REN);
      cyc(M_OP0 | M_LATCH);
      cyc(M_ACCL | M_SRC);
      cyc(M_GRANT);
      i_ld_req = 1'b0;
      cyc(M_GRANT);
      cyc(M_CLR);
      chk("add_acc", dp_acc, 8'h08);

      // ld_req beats run in IDLE
      i_ld_req = 1'b1; i_run = 1'b1;
      cyc(14'h0);
      i_ld_req = 1'b0; i_run = 1'b0;
      cyc(M_GRANT);
      cyc(M_CLR);
      cyc(14'h0);
      cyc(14'h0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trisc_sequencer.md
# trisc_sequencer

Multi-cycle fetch/decode/execute sequencer for the TRISC2 4-bit accumulator CPU. It drives every datapath strobe: PC increment/load/clear, RAM address select, RAM enable/write, IR load, ALU operation, ALU buffer latch and accumulator load. It also arbitrates the single 16x8 RAM port between the CPU and the manual switch loader. It sits between the IR and the datapath and replaces the fixed control-word tester.

## Interface
Parameters:
- OPW, 4, opcode width (IR[7:4]); operand is IR[3:0]

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; resets state and all outputs
- run  in  1  level; 1 = free-run, 0 = stop at the next instruction boundary
- step  in  1  one-cycle pulse; executes exactly one instruction from IDLE
- ir_op  in  4  opcode currently held in IR
- acc_zero, alu_cout  in  1 each  flags for conditional jumps
- ld_req  in  1  manual loader requests the RAM port (level)
- ld_grant  out  1  loader owns the RAM; CPU strobes are all 0
- pc_inc, pc_load, pc_clr  out  1 each  PC controls
- addr_sel  out  1  RAM address: 0 = PC, 1 = IR operand
- ram_en, ram_wr  out  1 each  RAM clock-enable and write-enable
- ir_load  out  1  capture RAM output into IR
- alu_op  out  2  00 pass, 01 add, 10 sub
- alu_latch  out  1  capture ALU result into buffer
- acc_load, acc_src  out  1 each  accumulator load; src 0 = RAM data, 1 = ALU buffer
- halted  out  1  FSM is in HALT

## Operation
- ISA: 0 NOP, 1 LDA a, 2 STA a, 3 ADD a, 4 SUB a, 5 JMP a, 6 JZ a, 7 JC a, F HLT; 8–E execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: enter FETCH when (run or step) and not ld_req; ld_req takes priority over run/step in the same cycle.
- FETCH: addr_sel=0, ram_en=1.
- DECODE: ir_load=1, pc_inc=1.
- EXEC by ir_op:
  - LDA/ADD/SUB: addr_sel=1, ram_en=1, go to MEM.
  - STA: addr_sel=1, ram_en=1, ram_wr=1, instruction ends.
  - JMP: pc_load=1. JZ: pc_load=acc_zero. JC: pc_load=alu_cout.
  - NOP: no strobes.
  - HLT: go to HALT.
- MEM:
  - LDA: acc_load=1, acc_src=0; end.
  - ADD/SUB: alu_op=01/10, alu_latch=1; go to WB.
- WB: acc_load=1, acc_src=1; end.
- End of instruction: go to FETCH if run=1, else IDLE. step is sampled only in IDLE.
- HALT: halted=1; leaves only on reset or via a loader session.
- Arbitration: ld_req sampled in IDLE or HALT raises ld_grant the next cycle. ld_grant holds while ld_req=1. On ld_req fall, ld_grant drops the next cycle with a one-cycle pc_clr pulse, and the state becomes IDLE.
- ld_req during any other state is ignored until the current instruction ends.

## Timing
- Reset: state IDLE; every output 0, including ld_grant and halted.
- RAM read latency is 1 cycle: data requested in FETCH/EXEC is valid in DECODE/MEM.
- Cycles per instruction: NOP/STA/JMP/JZ/JC = 3; LDA = 4; ADD/SUB = 5; HLT = 3 to reach HALT.
- All strobes are single-cycle Moore outputs of the current state, except pc_load, which is a function of registered flag inputs.
- Reset asserted mid-instruction aborts it: no partial write completes after reset; IDLE on the next edge.
- run dropping mid-instruction completes the instruction, then IDLE.
- step and run both high behave as run.

## Structure
- Shared package/include trisc_defs: opcode constants, state encoding, alu_op codes.
- One sub-module, trisc_decode: combinational mapping of (state, ir_op, flags) to the strobe vector. The top holds the state register and arbitration logic.

## Test plan
- Reset, run=1, RAM[0]=0x19 (LDA 9), RAM[9]=0x05 -> FETCH/DECODE/EXEC/MEM, acc_load with acc_src=0 in cycle 4, PC=1.
- ADD 0x3A with RAM[A]=0x03, acc=5 -> alu_op=01, alu_latch in MEM, acc_load with src=1 in WB; acc reaches 8; 5 cycles total.
- JZ 0x6C with acc_zero=0, then with acc_zero=1 -> pc_load 0, then pc_load 1 in EXEC; PC=C in the second case.
- HLT 0xF0 -> halted=1 after 3 cycles; run toggling has no effect; ld_req pulse -> grant, then pc_clr, then IDLE.
- ld_req raised during ADD -> ld_grant only after WB; no CPU strobe is ever active while ld_grant=1.
- run=0, step pulse in IDLE -> exactly one instruction, then IDLE; reset asserted during an STA EXEC cycle -> ram_wr=0 on the following cycle.
